// File: rtl/axi_pkg.sv
// Shared AXI interconnect definitions: address map, response codes, arbiter states and
// slave-select encodings used by the read and write channel controllers.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DFLT
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SEL_S0      = 3'd0;
  localparam logic [2:0] SEL_S1      = 3'd1;
  localparam logic [2:0] SEL_S2      = 3'd2;
  localparam logic [2:0] SEL_S3      = 3'd3;
  localparam logic [2:0] SEL_S4      = 3'd4;
  localparam logic [2:0] SEL_S5      = 3'd5;
  localparam logic [2:0] SEL_DEFAULT = 3'd6;
  localparam logic [2:0] SEL_NONE    = 3'd7;

  localparam logic [31:0] MASK_64K = 32'hFFFF_0000;
  localparam logic [31:0] MASK_16M = 32'hFF00_0000;

  localparam logic [31:0] S0_BASE = 32'h0000_0000;
  localparam logic [31:0] S1_BASE = 32'h0001_0000;
  localparam logic [31:0] S2_BASE = 32'h0002_0000;
  localparam logic [31:0] S3_BASE = 32'h1000_0000;
  localparam logic [31:0] S4_BASE = 32'h2000_0000;
  localparam logic [31:0] S5_BASE = 32'h3000_0000;

  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/axi_addr_decoder.sv
// Combinational address decoder: maps an address and requesting master index to a slave_sel
// code. Shared between the read and write channel arbiters.
module axi_addr_decoder
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 32
) (
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic                 mst_i,
  output logic [2:0]           slave_sel_o
);

  logic [31:0] addr;
  assign addr = addr_i[31:0];

  always_comb begin
    slave_sel_o = SEL_DEFAULT;
    if (addr_hit(addr, S0_BASE, MASK_64K)) begin
      slave_sel_o = SEL_S0;
    end else if (addr_hit(addr, S1_BASE, MASK_64K)) begin
      slave_sel_o = SEL_S1;
    end else if (addr_hit(addr, S2_BASE, MASK_64K)) begin
      slave_sel_o = SEL_S2;
    end else if (addr_hit(addr, S3_BASE, MASK_64K)) begin
      slave_sel_o = SEL_S3;
    end else if (addr_hit(addr, S4_BASE, MASK_16M)) begin
      slave_sel_o = SEL_S4;
    end else if (addr_hit(addr, S5_BASE, MASK_64K) && mst_i) begin
      // S5 is private to M1; M0 falls through to the default slave.
      slave_sel_o = SEL_S5;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// AXI read-channel controller: arbitrates AR between two masters, routes AR to the decoded
// slave, holds the grant until the last R beat, and serves DECERR beats for unmapped reads.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned ID_BITS   = 4,
  parameter int unsigned IDS_BITS  = 8,
  parameter int unsigned LEN_BITS  = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 ARVALID_M0,
  input  logic                 ARVALID_M1,
  input  logic [ADDR_BITS-1:0] ARADDR_M0,
  input  logic [ADDR_BITS-1:0] ARADDR_M1,
  input  logic [ID_BITS-1:0]   ARID_M0,
  input  logic [ID_BITS-1:0]   ARID_M1,
  input  logic [LEN_BITS-1:0]  ARLEN_M0,
  input  logic [LEN_BITS-1:0]  ARLEN_M1,
  output logic                 ARREADY_M0,
  output logic                 ARREADY_M1,
  output logic [5:0]           ARVALID_S,
  input  logic [5:0]           ARREADY_S,
  input  logic                 RVALID_sel,
  input  logic                 RLAST_sel,
  input  logic                 RREADY_sel,
  output logic                 grant,
  output logic [2:0]           slave_sel,
  output logic                 busy,
  output logic [IDS_BITS-1:0]  DS_RID,
  output logic [1:0]           DS_RRESP,
  output logic                 DS_RLAST,
  output logic                 DS_RVALID
);

  state_e               state_q;
  logic                 ptr_q;
  logic                 grant_q;
  logic [2:0]           sel_q;
  logic                 busy_q;
  logic [ID_BITS-1:0]   id_q;
  logic [LEN_BITS-1:0]  len_q;
  logic [LEN_BITS-1:0]  cnt_q;
  logic                 ds_rvalid_q;
  logic                 ds_rlast_q;
  logic [1:0]           ds_rresp_q;
  logic [IDS_BITS-1:0]  ds_rid_q;

  logic                 win;
  logic [ADDR_BITS-1:0] win_addr;
  logic [ID_BITS-1:0]   win_id;
  logic [LEN_BITS-1:0]  win_len;
  logic [2:0]           win_sel;
  logic                 arvalid_g;
  logic                 arready_g;
  logic                 ar_hs;

  // With both requesting the pointer decides; otherwise whoever is requesting wins.
  assign win      = (ARVALID_M0 && ARVALID_M1) ? ptr_q : ARVALID_M1;
  assign win_addr = win ? ARADDR_M1 : ARADDR_M0;
  assign win_id   = win ? ARID_M1 : ARID_M0;
  assign win_len  = win ? ARLEN_M1 : ARLEN_M0;

  axi_addr_decoder #(
    .ADDR_BITS(ADDR_BITS)
  ) u_dec (
    .addr_i      (win_addr),
    .mst_i       (win),
    .slave_sel_o (win_sel)
  );

  assign arvalid_g = grant_q ? ARVALID_M1 : ARVALID_M0;

  always_comb begin
    ARVALID_S = '0;
    arready_g = 1'b0;
    if (state_q == ADDR) begin
      if (sel_q == SEL_DEFAULT) begin
        arready_g = 1'b1;
      end else if (sel_q < SEL_DEFAULT) begin
        ARVALID_S[sel_q] = arvalid_g;
        arready_g        = ARREADY_S[sel_q];
      end
    end
  end

  assign ARREADY_M0 = arready_g && !grant_q;
  assign ARREADY_M1 = arready_g && grant_q;
  assign ar_hs      = arready_g && arvalid_g;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      grant_q     <= 1'b0;
      sel_q       <= SEL_NONE;
      busy_q      <= 1'b0;
      id_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      ds_rvalid_q <= 1'b0;
      ds_rlast_q  <= 1'b0;
      ds_rresp_q  <= RESP_OKAY;
      ds_rid_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ARVALID_M0 || ARVALID_M1) begin
            state_q <= ADDR;
            grant_q <= win;
            sel_q   <= win_sel;
            id_q    <= win_id;
            len_q   <= win_len;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            cnt_q <= '0;
            if (sel_q == SEL_DEFAULT) begin
              state_q     <= DFLT;
              ds_rvalid_q <= 1'b1;
              ds_rresp_q  <= RESP_DECERR;
              ds_rid_q    <= IDS_BITS'({grant_q, id_q});
              ds_rlast_q  <= (len_q == '0);
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (RVALID_sel && RREADY_sel) begin
            cnt_q <= cnt_q + 1'b1;
            if (RLAST_sel) begin
              state_q <= IDLE;
              ptr_q   <= !grant_q;
              sel_q   <= SEL_NONE;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
            end
          end
        end
        DFLT: begin
          if (ds_rvalid_q && RREADY_sel) begin
            if (ds_rlast_q) begin
              state_q     <= IDLE;
              ptr_q       <= !grant_q;
              sel_q       <= SEL_NONE;
              busy_q      <= 1'b0;
              cnt_q       <= '0;
              ds_rvalid_q <= 1'b0;
              ds_rlast_q  <= 1'b0;
              ds_rresp_q  <= RESP_OKAY;
              ds_rid_q    <= '0;
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              ds_rlast_q <= ((cnt_q + 1'b1) == len_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign slave_sel = sel_q;
  assign busy      = busy_q;
  assign DS_RVALID = ds_rvalid_q;
  assign DS_RLAST  = ds_rlast_q;
  assign DS_RRESP  = ds_rresp_q;
  assign DS_RID    = ds_rid_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a per-cycle vector table plus hand-written sequences
// for arbitration alternation and reset in the middle of a burst.
module tb_axi_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        ARVALID_M0, ARVALID_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1;
  logic [3:0]  ARID_M0, ARID_M1;
  logic [3:0]  ARLEN_M0, ARLEN_M1;
  logic        ARREADY_M0, ARREADY_M1;
  logic [5:0]  ARVALID_S, ARREADY_S;
  logic        RVALID_sel, RLAST_sel, RREADY_sel;
  logic        grant;
  logic [2:0]  slave_sel;
  logic        busy;
  logic [7:0]  DS_RID;
  logic [1:0]  DS_RRESP;
  logic        DS_RLAST, DS_RVALID;

  always #5 ACLK = ~ACLK;

  axi_read_arbiter dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .ARVALID_M0 (ARVALID_M0),
    .ARVALID_M1 (ARVALID_M1),
    .ARADDR_M0  (ARADDR_M0),
    .ARADDR_M1  (ARADDR_M1),
    .ARID_M0    (ARID_M0),
    .ARID_M1    (ARID_M1),
    .ARLEN_M0   (ARLEN_M0),
    .ARLEN_M1   (ARLEN_M1),
    .ARREADY_M0 (ARREADY_M0),
    .ARREADY_M1 (ARREADY_M1),
    .ARVALID_S  (ARVALID_S),
    .ARREADY_S  (ARREADY_S),
    .RVALID_sel (RVALID_sel),
    .RLAST_sel  (RLAST_sel),
    .RREADY_sel (RREADY_sel),
    .grant      (grant),
    .slave_sel  (slave_sel),
    .busy       (busy),
    .DS_RID     (DS_RID),
    .DS_RRESP   (DS_RRESP),
    .DS_RLAST   (DS_RLAST),
    .DS_RVALID  (DS_RVALID)
  );

  typedef struct packed {
    logic v0, v1; logic [31:0] a0, a1; logic [3:0] l0, l1; logic [5:0] ars;
    logic rv, rl, rr;
  } inp_t;
  typedef struct packed {
    logic rdy0, rdy1; logic [5:0] avs; logic gnt; logic [2:0] sel; logic bsy;
    logic dsv, dsl; logic [7:0] rid; logic [1:0] rresp;
  } exp_t;
  typedef struct packed { inp_t i; exp_t e; } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic inp_t mi(input logic v0, input logic v1, input logic [31:0] a0,
                              input logic [31:0] a1, input logic [3:0] l0, input logic [3:0] l1,
                              input logic [5:0] ars, input logic rv, input logic rl,
                              input logic rr);
    inp_t r;
    r.v0 = v0; r.v1 = v1; r.a0 = a0; r.a1 = a1; r.l0 = l0; r.l1 = l1;
    r.ars = ars; r.rv = rv; r.rl = rl; r.rr = rr;
    return r;
  endfunction

  function automatic exp_t me(input logic rdy0, input logic rdy1, input logic [5:0] avs,
                              input logic gnt, input logic [2:0] sel, input logic bsy,
                              input logic dsv, input logic dsl, input logic [7:0] rid,
                              input logic [1:0] rresp);
    exp_t r;
    r.rdy0 = rdy0; r.rdy1 = rdy1; r.avs = avs; r.gnt = gnt; r.sel = sel; r.bsy = bsy;
    r.dsv = dsv; r.dsl = dsl; r.rid = rid; r.rresp = rresp;
    return r;
  endfunction

  task automatic chk(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
    end
  endtask

  task automatic check_exp(input string tag, input exp_t e);
    chk(tag, "ARREADY_M0", 32'(ARREADY_M0), 32'(e.rdy0));
    chk(tag, "ARREADY_M1", 32'(ARREADY_M1), 32'(e.rdy1));
    chk(tag, "ARVALID_S", 32'(ARVALID_S), 32'(e.avs));
    chk(tag, "grant", 32'(grant), 32'(e.gnt));
    chk(tag, "slave_sel", 32'(slave_sel), 32'(e.sel));
    chk(tag, "busy", 32'(busy), 32'(e.bsy));
    chk(tag, "DS_RVALID", 32'(DS_RVALID), 32'(e.dsv));
    chk(tag, "DS_RLAST", 32'(DS_RLAST), 32'(e.dsl));
    chk(tag, "DS_RID", 32'(DS_RID), 32'(e.rid));
    chk(tag, "DS_RRESP", 32'(DS_RRESP), 32'(e.rresp));
  endtask

  task automatic apply(input inp_t i);
    ARVALID_M0 = i.v0; ARVALID_M1 = i.v1;
    ARADDR_M0  = i.a0; ARADDR_M1  = i.a1;
    ARLEN_M0   = i.l0; ARLEN_M1   = i.l1;
    ARREADY_S  = i.ars;
    RVALID_sel = i.rv; RLAST_sel = i.rl; RREADY_sel = i.rr;
  endtask

  task automatic add(input inp_t i, input exp_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    vq.push_back(v);
  endtask

  initial begin
    exp_t e_rst;
    inp_t i_idle;
    e_rst  = me(0, 0, 6'h00, 0, 3'd7, 0, 0, 0, 8'h00, 2'd0);
    i_idle = mi(0, 0, 32'h0, 32'h0, 4'd0, 4'd0, 6'h00, 0, 0, 0);
    ARID_M0 = 4'h5;
    ARID_M1 = 4'hA;
    apply(i_idle);
    ARESET = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    check_exp("reset", e_rst);
    ARESET = 1'b0;

    // M0 -> S1, 4 beats, S1 ready at once
    add(mi(1, 0, 32'h0001_0040, 0, 4'd3, 0, 6'h02, 0, 0, 0), e_rst);
    add(mi(1, 0, 32'h0001_0040, 0, 4'd3, 0, 6'h02, 0, 0, 0),
        me(1, 0, 6'h02, 0, 3'd1, 1, 0, 0, 8'h00, 2'd0));
    for (int k = 0; k < 3; k++) begin
      add(mi(0, 0, 0, 0, 0, 0, 6'h00, 1, 0, 1), me(0, 0, 6'h00, 0, 3'd1, 1, 0, 0, 8'h00, 2'd0));
    end
    add(mi(0, 0, 0, 0, 0, 0, 6'h00, 1, 1, 1), me(0, 0, 6'h00, 0, 3'd1, 1, 0, 0, 8'h00, 2'd0));
    add(i_idle, e_rst);
    // M0 -> 0x3000_0000 decodes to the default slave; 2 DECERR beats with a 2-cycle stall
    add(mi(1, 0, 32'h3000_0000, 0, 4'd1, 0, 6'h00, 0, 0, 0), e_rst);
    add(mi(1, 0, 32'h3000_0000, 0, 4'd1, 0, 6'h3F, 0, 0, 0),
        me(1, 0, 6'h00, 0, 3'd6, 1, 0, 0, 8'h00, 2'd0));
    add(mi(0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0), me(0, 0, 6'h00, 0, 3'd6, 1, 1, 0, 8'h05, 2'd3));
    add(mi(0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0), me(0, 0, 6'h00, 0, 3'd6, 1, 1, 0, 8'h05, 2'd3));
    add(mi(0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 1), me(0, 0, 6'h00, 0, 3'd6, 1, 1, 0, 8'h05, 2'd3));
    add(mi(0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 1), me(0, 0, 6'h00, 0, 3'd6, 1, 1, 1, 8'h05, 2'd3));
    add(i_idle, e_rst);
    // M1 -> S5 with ARREADY_S5 held low for 3 cycles
    add(mi(0, 1, 0, 32'h3000_0010, 0, 4'd0, 6'h00, 0, 0, 0), e_rst);
    for (int k = 0; k < 3; k++) begin
      add(mi(0, 1, 0, 32'h3000_0010, 0, 4'd0, 6'h00, 0, 0, 0),
          me(0, 0, 6'h20, 1, 3'd5, 1, 0, 0, 8'h00, 2'd0));
    end
    add(mi(0, 1, 0, 32'h3000_0010, 0, 4'd0, 6'h20, 0, 0, 0),
        me(0, 1, 6'h20, 1, 3'd5, 1, 0, 0, 8'h00, 2'd0));
    add(mi(0, 0, 0, 0, 0, 0, 6'h00, 1, 1, 1), me(0, 0, 6'h00, 1, 3'd5, 1, 0, 0, 8'h00, 2'd0));
    add(i_idle, me(0, 0, 6'h00, 1, 3'd7, 0, 0, 0, 8'h00, 2'd0));

    for (int k = 0; k < vq.size(); k++) begin
      apply(vq[k].i);
      #1;
      check_exp($sformatf("vec%0d", k), vq[k].e);
      @(negedge ACLK);
    end

    // Alternation: simultaneous requests after reset go M0, then M1, then M0 again
    apply(i_idle);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    apply(mi(1, 1, 32'h0000_0100, 32'h0002_0000, 4'd0, 4'd0, 6'h3F, 0, 0, 0));
    @(negedge ACLK);
    #1;
    chk("alt1", "grant", 32'(grant), 32'd0);
    chk("alt1", "slave_sel", 32'(slave_sel), 32'd0);
    chk("alt1", "ARREADY_M0", 32'(ARREADY_M0), 32'd1);
    chk("alt1", "ARVALID_S", 32'(ARVALID_S), 32'h01);
    @(negedge ACLK);
    apply(mi(0, 1, 32'h0, 32'h0002_0000, 4'd0, 4'd0, 6'h3F, 1, 1, 1));
    @(negedge ACLK);
    apply(mi(0, 1, 32'h0, 32'h0002_0000, 4'd0, 4'd0, 6'h3F, 0, 0, 0));
    #1;
    chk("alt_gap", "busy", 32'(busy), 32'd0);
    @(negedge ACLK);
    #1;
    chk("alt2", "grant", 32'(grant), 32'd1);
    chk("alt2", "slave_sel", 32'(slave_sel), 32'd2);
    chk("alt2", "ARREADY_M1", 32'(ARREADY_M1), 32'd1);
    chk("alt2", "ARVALID_S", 32'(ARVALID_S), 32'h04);
    @(negedge ACLK);
    apply(mi(0, 0, 32'h0, 32'h0, 4'd0, 4'd0, 6'h3F, 1, 1, 1));
    @(negedge ACLK);
    // M0 wins the next tie; M1 keeps requesting S1 behind it
    apply(mi(1, 1, 32'h0000_0100, 32'h0001_0000, 4'd0, 4'd3, 6'h3F, 0, 0, 0));
    @(negedge ACLK);
    #1;
    chk("alt3", "grant", 32'(grant), 32'd0);
    chk("alt3", "slave_sel", 32'(slave_sel), 32'd0);
    @(negedge ACLK);
    apply(mi(0, 1, 32'h0, 32'h0001_0000, 4'd0, 4'd3, 6'h3F, 1, 1, 1));
    @(negedge ACLK);
    apply(mi(0, 1, 32'h0, 32'h0001_0000, 4'd0, 4'd3, 6'h3F, 0, 0, 0));
    @(negedge ACLK);
    #1;
    chk("m1_s1", "grant", 32'(grant), 32'd1);
    chk("m1_s1", "slave_sel", 32'(slave_sel), 32'd1);
    @(negedge ACLK);
    // Reset lands on beat 2 of the M1 burst (pointer was left at M1)
    apply(mi(0, 0, 32'h0, 32'h0, 4'd0, 4'd0, 6'h00, 1, 0, 1));
    @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    check_exp("mid_rst", e_rst);
    ARESET = 1'b0;
    apply(mi(1, 1, 32'h0000_0100, 32'h0002_0000, 4'd0, 4'd0, 6'h3F, 0, 0, 0));
    @(negedge ACLK);
    #1;
    chk("post_rst", "grant", 32'(grant), 32'd0);
    chk("post_rst", "slave_sel", 32'(slave_sel), 32'd0);
    chk("post_rst", "ARREADY_M0", 32'(ARREADY_M0), 32'd1);
    @(negedge ACLK);
    apply(mi(0, 0, 32'h0, 32'h0, 4'd0, 4'd0, 6'h00, 1, 1, 1));
    @(negedge ACLK);
    apply(i_idle);
    #1;
    chk("post_rst_done", "busy", 32'(busy), 32'd0);
    chk("post_rst_done", "slave_sel", 32'(slave_sel), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Read-channel controller for the AXI interconnect: arbitrates AR requests from masters M0 and M1, decodes the granted address to one of six slaves or the default slave, and holds the grant until the last read beat completes. Its registered outputs drive the read slave-to-master mux select and AR routing. When an address decodes to no slave, it also acts as the default slave and returns DECERR beats.

## Interface
Parameters:
- ADDR_BITS, 32, address width
- ID_BITS, 4, master-side ARID width
- IDS_BITS, 8, slave-side ID width, {4-bit master index, ARID}
- LEN_BITS, 4, ARLEN width

Ports:
- ACLK  in  1  clock; one clock domain
- ARESET  in  1  reset; synchronous, active-high
- ARVALID_M0 / ARVALID_M1  in  1  address request from each master
- ARADDR_M0 / ARADDR_M1  in  ADDR_BITS  request address
- ARID_M0 / ARID_M1  in  ID_BITS  request ID
- ARLEN_M0 / ARLEN_M1  in  LEN_BITS  burst length minus 1
- ARREADY_M0 / ARREADY_M1  out  1  address accept to each master
- ARVALID_S  out  6  one-hot AR valid to S0..S5
- ARREADY_S  in  6  AR ready from S0..S5
- RVALID_sel, RLAST_sel  in  1  RVALID and RLAST of the currently selected slave, already muxed
- RREADY_sel  in  1  RREADY of the granted master
- grant  out  1  granted master index, 0 = M0, 1 = M1
- slave_sel  out  3  0..5 = S0..S5, 6 = default slave, 7 = none
- busy  out  1  high when the state is not IDLE
- DS_RID  out  IDS_BITS  default-slave RID
- DS_RRESP  out  2  default-slave RRESP
- DS_RLAST  out  1  default-slave RLAST
- DS_RVALID  out  1  default-slave RVALID

## Operation
Address map, decoded on the granted master's ARADDR:
- S0: [31:16] = 0x0000
- S1: [31:16] = 0x0001
- S2: [31:16] = 0x0002
- S3: [31:16] = 0x1000
- S4: [31:24] = 0x20
- S5: [31:16] = 0x3000, M1 only; an M0 access to this range decodes to the default slave
- Any other address: default slave

States:
- IDLE: if any ARVALID_Mx, grant the requester and latch grant, slave_sel, ID and LEN, then go to ADDR.
  - If both request, the priority pointer wins.
  - Pointer resets to M0.
- ADDR, real slave:
  - ARVALID_S[slave_sel] equals the granted ARVALID; ARREADY_M[grant] equals ARREADY_S[slave_sel].
  - On handshake, go to DATA.
- ADDR, default slave: ARREADY_M[grant] = 1, ARVALID_S = 0; go to DFLT on the next edge.
- DATA: count beats on RVALID_sel && RREADY_sel. On a handshake with RLAST_sel = 1, go to IDLE and set the pointer to the non-granted master.
- DFLT (default slave):
  - DS_RVALID = 1, DS_RRESP = 2'b11 (DECERR), DS_RID = {3'b0, grant, ARID}.
  - DS_RLAST = 1 when the beat counter equals the latched LEN.
  - The counter increments on DS_RVALID && RREADY_sel.
  - On the last handshake, go to IDLE and update the pointer.
- In any state other than ADDR, ARREADY_M* = 0 and ARVALID_S = 0.

## Timing
- Reset values:
  - State IDLE, pointer 0, grant 0, slave_sel 7, busy 0, beat counter 0.
  - ARVALID_S = 0, ARREADY_M* = 0.
  - DS_RVALID = 0, DS_RLAST = 0, DS_RRESP = 0, DS_RID = 0.
- Latency: request sampled in IDLE at edge N. Earliest AR handshake at cycle N+1. First R beat depends on the slave.
- grant, slave_sel, busy and all DS_* outputs are registered. ARREADY_M* and ARVALID_S are combinational from state and inputs.
- Back-to-back transactions: IDLE always lasts at least 1 cycle, so a new grant comes no earlier than 1 cycle after the last beat.
- If ARVALID drops in ADDR, which is an AXI violation, the block stays in ADDR. No recovery is required.
- A beat counter that does not match RLAST_sel is ignored for real slaves; RLAST_sel alone ends DATA.
- Reset asserted mid-burst: the block returns to reset values on the next edge. No beat is completed.
- RREADY_sel held low in DFLT: DS_RVALID, DS_RLAST and DS_RID stay stable.

## Structure
- Shared package axi_pkg holds:
  - The address-map base/mask constants.
  - The RESP_OKAY and RESP_DECERR constants.
  - The state enum typedef (IDLE, ADDR, DATA, DFLT).
  - The slave_sel encodings, including SEL_DEFAULT = 6 and SEL_NONE = 7.
- Sub-module axi_addr_decoder: combinational, takes address and master index, returns the 3-bit slave_sel. Reusable by the write-channel arbiter.

## Test plan
- M0 reads 0x0001_0040 with ARLEN = 3, S1 ready immediately, 4 beats, RLAST on beat 4 -> slave_sel = 1, ARVALID_S = 6'b000010, busy falls 1 cycle after beat 4.
- M0 and M1 request in the same cycle after reset -> M0 granted first, M1 granted immediately after M0's RLAST. A second simultaneous request then grants M0 again (alternation).
- M0 reads 0x3000_0000 with ARLEN = 1 -> slave_sel = 6, ARVALID_S = 0, 2 DECERR beats with DS_RID = {3'b0, 0, ARID}, DS_RLAST only on beat 2.
- M1 reads 0x3000_0010 -> slave_sel = 5, S5 handshake; ARREADY_S5 held low for 3 cycles -> ARREADY_M1 low for the same 3 cycles.
- RREADY_sel low for 2 cycles in DFLT -> DS_* outputs held stable and the counter does not advance.
- ARESET pulsed during DATA beat 2 -> all outputs return to reset values, pointer returns to 0, and the next request is serviced normally.
